lsu: RTL and testbench

//  Load/store unit downstream of the ALU. Consumes the ALU effective address plus rs2 store data for

---
 rtl/liang_pkg.sv | 25 ++
 rtl/lsu_align.sv | 41 ++++
 rtl/lsu.sv | 134 +++++++++++++
 tb/tb_lsu.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/liang_pkg.sv
// Shared types for the load/store unit: uop encoding, FSM states and the alignment rule.
package liang_pkg;

  localparam int unsigned LSU_WAIT_LIMIT = 255;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  typedef enum logic [2:0] {OP_ALU, OP_BRANCH, OP_LOAD, OP_STORE, OP_CSR} fu_op_t;

  typedef enum logic [2:0] {LB, LH, LW, LBU, LHU, SB, SH, SW} fu_func_t;

  typedef struct packed {
    fu_op_t   fu_op;
    fu_func_t fu_func;
  } uop_info_t;

  function automatic logic is_misaligned(input fu_func_t func, input logic [1:0] off);
    case (func)
      LH, LHU, SH: return off[0];
      LW, SW:      return |off;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replication and load extraction with sign/zero extension.
module lsu_align
  import liang_pkg::*;
(
  input  fu_func_t    func_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = 8'(rdata_i >> {off_i, 3'b000});
    w_half  = 16'(rdata_i >> {off_i[1], 4'b0000});
    wstrb_o = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (func_i)
      SB: begin
        wstrb_o = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SH: begin
        wstrb_o = 4'b0011 << off_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      SW:      wstrb_o = 4'b1111;
      LB:      rdata_o = {{24{w_byte[7]}}, w_byte};
      LBU:     rdata_o = {24'b0, w_byte};
      LH:      rdata_o = {{16{w_half[15]}}, w_half};
      LHU:     rdata_o = {16'b0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one valid/ready request plus one response per LOAD/STORE uop, with timeout.
module lsu
  import liang_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned WAIT_LIMIT = LSU_WAIT_LIMIT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  uop_info_t       uop_info_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            misalign_o,
  output logic            fault_o,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic            mem_req_we_o,
  output logic [XLEN-1:0] mem_req_addr_o,
  output logic [XLEN-1:0] mem_req_wdata_o,
  output logic [3:0]      mem_req_wstrb_o,
  input  logic            mem_rsp_valid_i,
  input  logic [XLEN-1:0] mem_rsp_rdata_i,
  input  logic            mem_rsp_err_i
);

  localparam int unsigned CntW = $clog2(WAIT_LIMIT + 1);

  lsu_state_t      r_state, w_state_nxt;
  uop_info_t       r_uop;
  logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
  logic            r_err, r_misalign;
  logic [CntW-1:0] r_cnt;

  logic            w_accept, w_misalign, w_timeout, w_to_fault;
  logic            w_req, w_done, w_we, w_rsp_take;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata_lane, w_rdata_ext;

  assign w_accept   = (r_state == IDLE) & valid_i & (uop_info_i.fu_op inside {OP_LOAD, OP_STORE});
  assign w_misalign = is_misaligned(uop_info_i.fu_func, addr_i[1:0]);
  // r_cnt holds cycles already spent, so this is the last permitted REQ/WAIT cycle
  assign w_timeout  = r_cnt >= CntW'(WAIT_LIMIT - 1);
  assign w_rsp_take = (r_state == WAIT) & mem_rsp_valid_i;

  always_comb begin
    w_state_nxt = r_state;
    w_to_fault  = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_misalign ? DONE : REQ;
      REQ: begin
        if (mem_req_ready_i) begin
          w_state_nxt = WAIT;
        end else if (w_timeout) begin
          w_state_nxt = DONE;
          w_to_fault  = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rsp_valid_i) begin
          w_state_nxt = DONE;
        end else if (w_timeout) begin
          w_state_nxt = DONE;
          w_to_fault  = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_uop      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_misalign <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_uop      <= uop_info_i;
        r_addr     <= addr_i;
        r_wdata    <= wdata_i;
        r_rdata    <= '0;
        r_err      <= 1'b0;
        r_misalign <= w_misalign;
        r_cnt      <= '0;
      end else begin
        if ((r_state == REQ || r_state == WAIT) && r_cnt != CntW'(WAIT_LIMIT)) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_rsp_take) begin
          r_rdata <= mem_rsp_rdata_i;
          r_err   <= mem_rsp_err_i;
        end else if (w_to_fault) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  lsu_align u_align (
    .func_i  (r_uop.fu_func),
    .off_i   (r_addr[1:0]),
    .wdata_i (r_wdata),
    .rdata_i (r_rdata),
    .wstrb_o (w_wstrb),
    .wdata_o (w_wdata_lane),
    .rdata_o (w_rdata_ext)
  );

  assign w_req  = r_state == REQ;
  assign w_done = r_state == DONE;
  assign w_we   = r_uop.fu_op == OP_STORE;

  assign busy_o          = (r_state != IDLE) & ~w_done;
  assign done_o          = w_done;
  assign misalign_o      = w_done & r_misalign;
  assign fault_o         = w_done & r_err;
  assign rdata_o         = (w_done & ~w_we & ~r_err & ~r_misalign) ? w_rdata_ext : '0;
  assign mem_req_valid_o = w_req;
  assign mem_req_we_o    = w_req & w_we;
  assign mem_req_addr_o  = w_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign mem_req_wdata_o = (w_req & w_we) ? w_wdata_lane : '0;
  assign mem_req_wstrb_o = (w_req & w_we) ? w_wstrb : 4'b0000;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, corner sequences, randomized model checks.
module tb_lsu;
  import liang_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  uop_info_t   uop_info_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o, misalign_o, fault_o;
  logic [31:0] rdata_o;
  logic        mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
  logic [31:0] mem_req_addr_o, mem_req_wdata_o;
  logic [3:0]  mem_req_wstrb_o;
  logic        mem_rsp_valid_i, mem_rsp_err_i;
  logic [31:0] mem_rsp_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  lsu #(.XLEN(32), .WAIT_LIMIT(8)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .valid_i         (valid_i),
    .uop_info_i      (uop_info_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .rdata_o         (rdata_o),
    .misalign_o      (misalign_o),
    .fault_o         (fault_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_we_o    (mem_req_we_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_wdata_o (mem_req_wdata_o),
    .mem_req_wstrb_o (mem_req_wstrb_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_rdata_i (mem_rsp_rdata_i),
    .mem_rsp_err_i   (mem_rsp_err_i)
  );

  typedef struct {
    fu_op_t      op;
    fu_func_t    f;
    logic [31:0] a, wd, rsp;
    logic        err;
    int          rdly, sdly;
    logic [3:0]  strb;
    logic [31:0] wdo, rd;
    logic        mis;
  } vec_t;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic int unsigned size_of(input fu_func_t f);
    if (f inside {LB, LBU, SB}) return 1;
    if (f inside {LH, LHU, SH}) return 2;
    return 4;
  endfunction

  // Reference model: access size, lane position and extension computed with plain arithmetic
  function automatic void model(input fu_func_t f, input logic [31:0] a, wd, rsp, input logic err,
                                output logic [3:0] strb, output logic [31:0] wdo,
                                output logic [31:0] rd, output logic mis);
    int unsigned sz, off;
    logic [31:0] v;
    logic        store;
    sz    = size_of(f);
    off   = a % 4;
    store = f inside {SB, SH, SW};
    mis   = (a % sz) != 0;
    strb  = store ? 4'(((32'd1 << sz) - 1) << off) : 4'h0;
    if (sz == 1)      wdo = 32'(wd[7:0]) * 32'h0101_0101;
    else if (sz == 2) wdo = 32'(wd[15:0]) * 32'h0001_0001;
    else              wdo = wd;
    v = rsp >> (8 * off);
    if (sz == 1) v = v % 256;
    if (sz == 2) v = v % 65536;
    if (f == LB && v >= 128)   v = v | 32'hFFFF_FF00;
    if (f == LH && v >= 32768) v = v | 32'hFFFF_0000;
    rd = (store || err || mis) ? 32'h0 : v;
  endfunction

  task automatic run_txn(input fu_op_t op, input fu_func_t f, input logic [31:0] a, wd, rsp,
                         input logic err, input int rdly, sdly, input logic [3:0] strb,
                         input logic [31:0] wdo, rd, input logic mis);
    valid_i    = 1'b1;
    uop_info_i = '{fu_op: op, fu_func: f};
    addr_i     = a;
    wdata_i    = wd;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    addr_i  = $urandom;
    wdata_i = $urandom;
    if (!mis) begin
      for (int i = 0; i <= rdly; i++) begin
        chk("req_valid", 32'(mem_req_valid_o), 32'd1);
        chk("req_addr", mem_req_addr_o, a & 32'hFFFF_FFFC);
        chk("req_we", 32'(mem_req_we_o), 32'(op == OP_STORE));
        chk("req_wstrb", 32'(mem_req_wstrb_o), 32'(strb));
        if (op == OP_STORE) chk("req_wdata", mem_req_wdata_o, wdo);
        if (i == rdly) mem_req_ready_i = 1'b1;
        @(posedge clk_i); #1;
        mem_req_ready_i = 1'b0;
      end
      for (int i = 0; i <= sdly; i++) begin
        chk("wait_busy", 32'(busy_o), 32'd1);
        chk("wait_noreq", 32'(mem_req_valid_o), 32'd0);
        if (i == sdly) begin
          mem_rsp_valid_i = 1'b1;
          mem_rsp_rdata_i = rsp;
          mem_rsp_err_i   = err;
        end
        @(posedge clk_i); #1;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_err_i   = 1'b0;
      end
    end
    chk("done", 32'(done_o), 32'd1);
    chk("done_busy", 32'(busy_o), 32'd0);
    chk("done_noreq", 32'(mem_req_valid_o), 32'd0);
    chk("rdata", rdata_o, rd);
    chk("misalign", 32'(misalign_o), 32'(mis));
    chk("fault", 32'(fault_o), 32'(err & ~mis));
    @(posedge clk_i); #1;
    chk("done_pulse", 32'(done_o), 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd0);
  endtask

  vec_t        tbl [12];
  logic [3:0]  m_strb;
  logic [31:0] m_wdo, m_rd, ra, rwd, rrsp;
  logic        m_mis, rerr;
  fu_func_t    rf;

  initial begin
    tbl[0]  = '{OP_LOAD,  LW,  32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 0, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[1]  = '{OP_LOAD,  LB,  32'h8000_0003, 32'h0, 32'h80FF_FFFF, 1'b0, 0, 1, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b0};
    tbl[2]  = '{OP_LOAD,  LBU, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 1'b0, 1, 0, 4'h0, 32'h0, 32'h0000_0080, 1'b0};
    tbl[3]  = '{OP_LOAD,  LHU, 32'h8000_0002, 32'h0, 32'h8001_0000, 1'b0, 0, 2, 4'h0, 32'h0, 32'h0000_8001, 1'b0};
    tbl[4]  = '{OP_STORE, SH,  32'h8000_0002, 32'h1234_ABCD, 32'h0, 1'b0, 3, 0, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0};
    tbl[5]  = '{OP_LOAD,  LW,  32'h8000_0002, 32'h0, 32'h0, 1'b0, 0, 0, 4'h0, 32'h0, 32'h0, 1'b1};
    tbl[6]  = '{OP_LOAD,  LH,  32'h0000_1001, 32'h0, 32'h0, 1'b0, 0, 0, 4'h0, 32'h0, 32'h0, 1'b1};
    tbl[7]  = '{OP_STORE, SB,  32'h0000_2001, 32'hFFFF_FF55, 32'h0, 1'b0, 0, 1, 4'b0010, 32'h5555_5555, 32'h0, 1'b0};
    tbl[8]  = '{OP_LOAD,  LH,  32'h0000_3002, 32'h0, 32'h8001_1234, 1'b0, 2, 1, 4'h0, 32'h0, 32'hFFFF_8001, 1'b0};
    tbl[9]  = '{OP_LOAD,  LW,  32'h0000_4000, 32'h0, 32'h1234_5678, 1'b1, 0, 0, 4'h0, 32'h0, 32'h0, 1'b0};
    tbl[10] = '{OP_STORE, SW,  32'h0000_0010, 32'hCAFE_F00D, 32'h0, 1'b0, 1, 1, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0};
    tbl[11] = '{OP_LOAD,  LB,  32'h0000_0501, 32'h0, 32'h0000_7F00, 1'b0, 0, 0, 4'h0, 32'h0, 32'h0000_007F, 1'b0};

    rst_i = 1'b1; valid_i = 1'b0; uop_info_i = '0; addr_i = '0; wdata_i = '0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_rdata_i = '0; mem_rsp_err_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_req", 32'(mem_req_valid_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_flags", {30'd0, misalign_o, fault_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    for (int i = 0; i < 12; i++) begin
      run_txn(tbl[i].op, tbl[i].f, tbl[i].a, tbl[i].wd, tbl[i].rsp, tbl[i].err, tbl[i].rdly,
              tbl[i].sdly, tbl[i].strb, tbl[i].wdo, tbl[i].rd, tbl[i].mis);
    end

    // Non-memory uop must be ignored
    valid_i = 1'b1; uop_info_i = '{fu_op: OP_ALU, fu_func: LW}; addr_i = 32'h40;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    chk("alu_ignored_busy", 32'(busy_o), 32'd0);
    chk("alu_ignored_req", 32'(mem_req_valid_o), 32'd0);

    // Timeout: accepted by the bus but never answered
    valid_i = 1'b1; uop_info_i = '{fu_op: OP_LOAD, fu_func: LW}; addr_i = 32'h0000_0800;
    @(posedge clk_i); #1;
    valid_i = 1'b0; mem_req_ready_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("to_pending", 32'(done_o), 32'd0);
      @(posedge clk_i); #1;
      mem_req_ready_i = 1'b0;
    end
    chk("to_done", 32'(done_o), 32'd1);
    chk("to_fault", 32'(fault_o), 32'd1);
    chk("to_rdata", rdata_o, 32'd0);
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 32'h1111_2222;
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b0;
    chk("late_rsp_done", 32'(done_o), 32'd0);
    chk("late_rsp_busy", 32'(busy_o), 32'd0);

    // Reset while waiting for a response aborts silently
    valid_i = 1'b1; uop_info_i = '{fu_op: OP_LOAD, fu_func: LW}; addr_i = 32'h0000_0900;
    @(posedge clk_i); #1;
    valid_i = 1'b0; mem_req_ready_i = 1'b1;
    @(posedge clk_i); #1;
    mem_req_ready_i = 1'b0; rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_req", {27'd0, mem_req_valid_o, mem_req_wstrb_o}, 32'd0);
    chk("abort_out", rdata_o | mem_req_addr_o | {30'd0, fault_o, misalign_o}, 32'd0);
    mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 32'h3333_4444;
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b0;
    chk("abort_rsp_dropped", 32'(done_o), 32'd0);
    @(posedge clk_i); #1;
    chk("abort_still_idle", {30'd0, done_o, busy_o}, 32'd0);

    // valid_i while busy is ignored
    valid_i = 1'b1; uop_info_i = '{fu_op: OP_STORE, fu_func: SW}; addr_i = 32'h100;
    wdata_i = 32'h11;
    @(posedge clk_i); #1;
    uop_info_i = '{fu_op: OP_LOAD, fu_func: LW}; addr_i = 32'h200;
    for (int k = 0; k < 2; k++) begin
      chk("busy_hold_addr", mem_req_addr_o, 32'h100);
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0; mem_req_ready_i = 1'b1;
    @(posedge clk_i); #1;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1;
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b0;
    chk("busy_first_done", 32'(done_o), 32'd1);
    @(posedge clk_i); #1;
    chk("busy_no_second", {30'd0, mem_req_valid_o, busy_o}, 32'd0);

    // Randomized transactions against the reference model
    for (int n = 0; n < 60; n++) begin
      rf   = fu_func_t'($urandom_range(0, 7));
      ra   = $urandom;
      if ($urandom_range(0, 3) != 0) ra = ra & ~(size_of(rf) - 1);
      rwd  = $urandom;
      rrsp = $urandom;
      rerr = ($urandom_range(0, 7) == 0);
      model(rf, ra, rwd, rrsp, rerr, m_strb, m_wdo, m_rd, m_mis);
      run_txn((rf inside {SB, SH, SW}) ? OP_STORE : OP_LOAD, rf, ra, rwd, rrsp, rerr,
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), m_strb, m_wdo, m_rd, m_mis);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
